memory_stage: RTL and testbench

Memory-access stage of the 16-bit pipeline, sitting between the EX/MEM buffer and the MEM/WB buffer. It performs data-memory reads and writes over a ready-handshaked port and sequences two-beat CALL pushes and RET pops of the 32-bit return PC. It resolves conditional branches from the forwarded flags and stalls upstream buffers while an access is outstanding. All results are registered toward write-back.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/branch_resolve.sv | 21 ++
 rtl/memory_stage.sv | 155 +++++++++++++++
 tb/tb_memory_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipeline: widths, flag indices,
// memory-stage FSM states and the operation classifier.
package cpu_pkg;
  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int REG_AW = 3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {S_IDLE, S_BEAT1, S_BEAT2} state_e;
  typedef enum logic [1:0] {OP_NONE, OP_SINGLE, OP_PUSHPC, OP_POPPC} opclass_e;

  // Both PC flags mark a two-beat return-PC transfer; direction comes from read/write.
  function automatic opclass_e classify(input logic rd, input logic wr,
                                        input logic pcHi, input logic pcLo);
    opclass_e c;
    c = OP_NONE;
    if (pcHi && pcLo && wr)      c = OP_PUSHPC;
    else if (pcHi && pcLo && rd) c = OP_POPPC;
    else if (rd || wr)           c = OP_SINGLE;
    return c;
  endfunction
endpackage

// File: rtl/branch_resolve.sv
// Conditional-branch decision from {V,C,N,Z} flags and the jump-select bits.
// An unconditional branch is inBranch with no J* bit set.
module branch_resolve
  import cpu_pkg::*;
(
  input  logic       branch,
  input  logic       jz,
  input  logic       jc,
  input  logic       jn,
  input  logic [3:0] flags,
  output logic       taken
);
  // Overflow is carried in the flag word but no jump condition tests it.
  logic unusedV;
  assign unusedV = flags[FLAG_V];

  assign taken = branch & (~(jz | jc | jn)
                           | (jz & flags[FLAG_Z])
                           | (jc & flags[FLAG_C])
                           | (jn & flags[FLAG_N]));
endmodule

// File: rtl/memory_stage.sv
// Memory-access stage: single loads/stores, two-beat CALL push / RET pop of the
// return PC, branch resolution and upstream stall, with registered write-back.
module memory_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inAluData,
  input  logic [DATA_W-1:0] inRdstData,
  input  logic [REG_AW-1:0] inRdstAddress,
  input  logic              inWB,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic              inBranch,
  input  logic              inJZ,
  input  logic              inJC,
  input  logic              inJN,
  input  logic [3:0]        inFlags,
  input  logic              inWritePcHigh,
  input  logic              inWritePcLow,
  input  logic [PC_W-1:0]   inPc,
  output logic              memReq,
  output logic              memWe,
  output logic [DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData,
  input  logic              memReady,
  output logic              stallOut,
  output logic [DATA_W-1:0] wbData,
  output logic [REG_AW-1:0] wbRdstAddress,
  output logic              wbWB,
  output logic              pcLoad,
  output logic [PC_W-1:0]   pcValue,
  output logic              flushOut,
  output logic              memError
);
  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

  state_e            state, stateNext;
  opclass_e          opCls, opClsQ;
  logic [3:0]        beatCnt;
  logic [DATA_W-1:0] popHigh;
  logic              taken, lastBeat, beatDone, timeout;

  assign opCls    = classify(inMemRead, inMemWrite, inWritePcHigh, inWritePcLow);
  assign lastBeat = (state == S_BEAT2) || (opClsQ == OP_SINGLE);

  branch_resolve uBranch (
    .branch(inBranch),
    .jz    (inJZ),
    .jc    (inJC),
    .jn    (inJN),
    .flags (inFlags),
    .taken (taken)
  );

  always_comb begin
    stateNext = state;
    memReq    = 1'b0;
    memWe     = 1'b0;
    memAddr   = '0;
    memWData  = '0;
    stallOut  = 1'b0;
    beatDone  = 1'b0;
    timeout   = 1'b0;
    case (state)
      S_IDLE: begin
        if (opCls != OP_NONE) begin
          stateNext = S_BEAT1;
          stallOut  = 1'b1;
        end
      end
      S_BEAT1, S_BEAT2: begin
        memReq  = 1'b1;
        memWe   = inMemWrite;
        memAddr = (state == S_BEAT1) ? inAluData : inAluData + 16'd1;
        if (inMemWrite) begin
          if (opClsQ == OP_PUSHPC)
            memWData = (state == S_BEAT1) ? inPc[31:16] : inPc[15:0];
          else
            memWData = inRdstData;
        end
        // Releasing the stall on the final ready lets upstream advance on the same edge
        // that returns us to IDLE, so the next op is seen exactly once.
        if (memReady) begin
          beatDone  = 1'b1;
          stateNext = lastBeat ? S_IDLE : S_BEAT2;
          stallOut  = ~lastBeat;
        end else if (beatCnt == TO_LAST) begin
          timeout   = 1'b1;
          stateNext = S_IDLE;
        end else begin
          stallOut  = 1'b1;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      opClsQ        <= OP_NONE;
      beatCnt       <= '0;
      popHigh       <= '0;
      wbData        <= '0;
      wbRdstAddress <= '0;
      wbWB          <= 1'b0;
      pcLoad        <= 1'b0;
      pcValue       <= '0;
      flushOut      <= 1'b0;
      memError      <= 1'b0;
    end else begin
      state    <= stateNext;
      wbWB     <= 1'b0;
      pcLoad   <= 1'b0;
      flushOut <= 1'b0;

      if (stateNext != state)    beatCnt <= '0;
      else if (state != S_IDLE)  beatCnt <= beatCnt + 4'd1;

      if (state == S_IDLE) begin
        opClsQ <= opCls;
        if (opCls == OP_NONE) begin
          wbData        <= inAluData;
          wbRdstAddress <= inRdstAddress;
          wbWB          <= inWB;
        end
        if (taken) begin
          pcLoad   <= 1'b1;
          flushOut <= 1'b1;
          pcValue  <= {16'b0, inRdstData};
        end
      end

      if (beatDone && state == S_BEAT1 && opClsQ == OP_POPPC)
        popHigh <= memRData;

      if (beatDone && lastBeat) begin
        wbRdstAddress <= inRdstAddress;
        wbWB          <= inWB;
        wbData        <= (opClsQ == OP_SINGLE && inMemRead) ? memRData : inAluData;
        if (opClsQ == OP_POPPC) begin
          pcLoad   <= 1'b1;
          flushOut <= 1'b1;
          pcValue  <= {popHigh, memRData};
        end
      end

      if (timeout) memError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a transaction-level model (memory array,
// per-beat ready delays) predicts every cycle of each op and its write-back.
module tb_memory_stage;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] inAluData, inRdstData;
  logic [2:0]  inRdstAddress;
  logic        inWB, inMemRead, inMemWrite, inBranch, inJZ, inJC, inJN;
  logic [3:0]  inFlags;
  logic        inWritePcHigh, inWritePcLow;
  logic [31:0] inPc;
  logic        memReq, memWe;
  logic [15:0] memAddr, memWData, memRData;
  logic        memReady, stallOut;
  logic [15:0] wbData;
  logic [2:0]  wbRdstAddress;
  logic        wbWB, pcLoad, flushOut, memError;
  logic [31:0] pcValue;

  memory_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .inAluData(inAluData), .inRdstData(inRdstData), .inRdstAddress(inRdstAddress),
    .inWB(inWB), .inMemRead(inMemRead), .inMemWrite(inMemWrite),
    .inBranch(inBranch), .inJZ(inJZ), .inJC(inJC), .inJN(inJN), .inFlags(inFlags),
    .inWritePcHigh(inWritePcHigh), .inWritePcLow(inWritePcLow), .inPc(inPc),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady), .stallOut(stallOut),
    .wbData(wbData), .wbRdstAddress(wbRdstAddress), .wbWB(wbWB),
    .pcLoad(pcLoad), .pcValue(pcValue), .flushOut(flushOut), .memError(memError)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  int  nTests = 0;
  int  nFail  = 0;
  bit  expErr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearIn();
    inAluData = '0; inRdstData = '0; inRdstAddress = '0; inWB = 0;
    inMemRead = 0; inMemWrite = 0; inBranch = 0; inJZ = 0; inJC = 0; inJN = 0;
    inFlags = '0; inWritePcHigh = 0; inWritePcLow = 0; inPc = '0;
  endtask

  // One instruction held at the stage until it completes, then one flushed
  // NOP cycle on which the registered results are checked.
  task automatic runOp(input bit rd, input bit wr, input bit pp,
                       input logic [15:0] alu, input logic [15:0] rdst,
                       input logic [2:0] ra, input bit wb,
                       input bit br, input bit jz, input bit jc, input bit jn,
                       input logic [3:0] fl, input logic [31:0] pc,
                       input int d0, input int d1);
    bit isMem, aborted, taken, last, rdyNow, toNow, expLoad;
    int nBeats, dl;
    logic [15:0] a1, addr, wd, rd0, rd1;
    a1  = alu + 16'd1;
    rd0 = mem[alu];
    rd1 = mem[a1];
    isMem  = rd | wr;
    nBeats = !isMem ? 0 : (pp ? 2 : 1);
    taken  = !isMem && br && (!(jz || jc || jn) || (jz && fl[0]) || (jc && fl[2]) || (jn && fl[1]));

    @(posedge clk); #1;
    inAluData = alu; inRdstData = rdst; inRdstAddress = ra; inWB = wb;
    inMemRead = rd; inMemWrite = wr; inBranch = br; inJZ = jz; inJC = jc; inJN = jn;
    inFlags = fl; inWritePcHigh = pp; inWritePcLow = pp; inPc = pc;
    memReady = 1'($urandom_range(0, 1)); memRData = 16'($urandom);
    @(negedge clk);
    chk("idle.memReq", memReq, 0);
    chk("idle.stall", stallOut, isMem);
    chk("idle.wbWB", wbWB, 0);
    chk("idle.pcLoad", pcLoad, 0);

    aborted = 0;
    for (int b = 0; b < nBeats && !aborted; b++) begin
      dl   = (b == 0) ? d0 : d1;
      addr = (b == 0) ? alu : a1;
      wd   = pp ? ((b == 0) ? pc[31:16] : pc[15:0]) : rdst;
      last = (b == nBeats - 1);
      for (int k = 0; k < TIMEOUT; k++) begin
        @(posedge clk); #1;
        rdyNow   = (k == dl);
        toNow    = !rdyNow && (k == TIMEOUT - 1);
        memReady = rdyNow;
        memRData = (rdyNow && rd) ? ((b == 0) ? rd0 : rd1) : 16'($urandom);
        @(negedge clk);
        chk("beat.memReq", memReq, 1);
        chk("beat.memWe", memWe, wr);
        chk("beat.addr", memAddr, addr);
        if (wr) chk("beat.wdata", memWData, wd);
        chk("beat.stall", stallOut, !((rdyNow && last) || toNow));
        chk("beat.wbWB", wbWB, 0);
        if (rdyNow) begin
          if (wr) mem[addr] = wd;
          break;
        end
        if (toNow) begin
          aborted = 1;
          expErr  = 1;
        end
      end
    end

    @(posedge clk); #1;
    clearIn();
    memReady = 1'($urandom_range(0, 1));
    memRData = 16'($urandom);
    @(negedge clk);
    chk("wb.wbWB", wbWB, aborted ? 1'b0 : wb);
    if (!aborted && wb) begin
      chk("wb.data", wbData, (rd && !pp) ? rd0 : alu);
      chk("wb.rdst", wbRdstAddress, ra);
    end
    expLoad = isMem ? (pp && rd && !aborted) : taken;
    chk("wb.pcLoad", pcLoad, expLoad);
    chk("wb.flush", flushOut, expLoad);
    if (expLoad) chk("wb.pcValue", pcValue, (isMem ? {rd0, rd1} : {16'h0, rdst}));
    chk("wb.memReq", memReq, 0);
    chk("wb.stall", stallOut, 0);
    chk("wb.memError", memError, expErr);
  endtask

  initial begin
    int op, d0, d1;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    clearIn();
    memReady = 0; memRData = '0;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.memReq", memReq, 0);
    chk("rst.stall", stallOut, 0);
    chk("rst.wbWB", wbWB, 0);
    chk("rst.pcLoad", pcLoad, 0);
    chk("rst.flush", flushOut, 0);
    chk("rst.memError", memError, 0);
    chk("rst.wbData", wbData, 0);
    chk("rst.pcValue", pcValue, 0);
    chk("rst.addr", {memAddr, memWData}, 0);
    @(posedge clk); #1 rst = 0;

    // ALU pass-through
    runOp(0, 0, 0, 16'h1234, 16'h0, 3'd3, 1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0);
    // load, ready after two wait cycles
    mem[16'h0010] = 16'hBEEF;
    runOp(1, 0, 0, 16'h0010, 16'h0, 3'd5, 1, 0, 0, 0, 0, 4'h0, 32'h0, 2, 0);
    // store
    runOp(0, 1, 0, 16'h0420, 16'h5A5A, 3'd1, 0, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0);
    chk("store.mem", mem[16'h0420], 16'h5A5A);
    // CALL push wrapping from FFFF to 0000
    runOp(0, 1, 1, 16'hFFFF, 16'h0, 3'd0, 0, 0, 0, 0, 0, 4'h0, 32'h0001_0040, 0, 1);
    chk("push.hi", mem[16'hFFFF], 16'h0001);
    chk("push.lo", mem[16'h0000], 16'h0040);
    // RET pop
    mem[16'h0200] = 16'h0002; mem[16'h0201] = 16'h0100;
    runOp(1, 0, 1, 16'h0200, 16'h0, 3'd0, 0, 0, 0, 0, 0, 4'h0, 32'h0, 1, 0);
    // JZ taken / not taken, JC and JN, unconditional
    runOp(0, 0, 0, 16'h0, 16'h0080, 3'd0, 0, 1, 1, 0, 0, 4'b0001, 32'h0, 0, 0);
    runOp(0, 0, 0, 16'h0, 16'h0080, 3'd0, 0, 1, 1, 0, 0, 4'b1110, 32'h0, 0, 0);
    runOp(0, 0, 0, 16'h0, 16'h0C00, 3'd0, 0, 1, 0, 1, 0, 4'b0100, 32'h0, 0, 0);
    runOp(0, 0, 0, 16'h0, 16'h0C00, 3'd0, 0, 1, 0, 0, 1, 4'b1101, 32'h0, 0, 0);
    runOp(0, 0, 0, 16'h0, 16'hABCD, 3'd0, 0, 1, 0, 0, 0, 4'b0000, 32'h0, 0, 0);
    // ready on the very last permitted cycle, then never
    runOp(1, 0, 0, 16'h0300, 16'h0, 3'd2, 1, 0, 0, 0, 0, 4'h0, 32'h0, TIMEOUT - 1, 0);
    runOp(1, 0, 0, 16'h0300, 16'h0, 3'd2, 1, 0, 0, 0, 0, 4'h0, 32'h0, 99, 0);
    runOp(0, 0, 0, 16'h7777, 16'h0, 3'd4, 1, 0, 0, 0, 0, 4'h0, 32'h0, 0, 0);

    // reset in the middle of BEAT2 of a pop
    @(posedge clk); #1;
    inAluData = 16'h0200; inMemRead = 1; inWritePcHigh = 1; inWritePcLow = 1; inWB = 1;
    memReady = 0;
    @(posedge clk); #1 memReady = 1; memRData = 16'h0002;
    @(posedge clk); #1 memReady = 0; rst = 1;
    @(negedge clk);
    chk("rstmid.beat2Req", memReq, 1);
    chk("rstmid.beat2Addr", memAddr, 16'h0201);
    @(posedge clk); #1 rst = 0; clearIn();
    @(negedge clk);
    chk("rstmid.memReq", memReq, 0);
    chk("rstmid.wbWB", wbWB, 0);
    chk("rstmid.pcLoad", pcLoad, 0);
    chk("rstmid.memError", memError, 0);
    expErr = 0;

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 4);
      d0 = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
      d1 = ($urandom_range(0, 19) == 0) ? 40 : $urandom_range(0, 3);
      runOp(op == 1 || op == 4, op == 2 || op == 3, op >= 3,
            16'($urandom), 16'($urandom), 3'($urandom), 1'($urandom),
            (op == 0) ? 1'($urandom) : 1'b0,
            1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom),
            $urandom, d0, d1);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
